// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serial RAM sequencer: access sizes, FSM states,
// request descriptor and the size-to-last-lane helper.
package mem_ctrl_pkg;

   localparam int NUM_LANES = 4;
   localparam int VEC_W     = 8;
   localparam int STAGES    = 1;

   localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
   localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
   localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ISSUE   = 2'd1;
   localparam logic [1:0] ST_LAST_RD = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_e;

   typedef struct packed {
      owner_e     owner;
      logic       we;
      logic [1:0] last;
   } req_t;

   // Index of the final byte lane for a size code; code 3 behaves as a word.
   function automatic logic [1:0] last_lane(input logic [1:0] size);
      case (size)
         MEM_SIZE_BYTE: last_lane = 2'd0;
         MEM_SIZE_HALF: last_lane = 2'd1;
         default:       last_lane = 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// CPU-side request/response and RAM-side byte port of mem_ctrl; slave is the
// controller's view, master is the view of the pipeline stages plus RAM.
interface mem_ctrl_if #(
   parameter int ADDR_W     = 32,
   parameter int RAM_ADDR_W = 17
);
   logic                  if_req_i;
   logic [ADDR_W-1:0]     if_addr_i;
   logic                  if_done_o;
   logic [31:0]           if_inst_o;
   logic                  ls_req_i;
   logic                  ls_we_i;
   logic [1:0]            ls_size_i;
   logic [ADDR_W-1:0]     ls_addr_i;
   logic [31:0]           ls_wdata_i;
   logic                  ls_done_o;
   logic [31:0]           ls_rdata_o;
   logic [RAM_ADDR_W-1:0] ram_addr_o;
   logic                  ram_we_o;
   logic [7:0]            ram_dout_o;
   logic [7:0]            ram_din_i;

   modport slave (
      input  if_req_i, if_addr_i, ls_req_i, ls_we_i, ls_size_i, ls_addr_i,
             ls_wdata_i, ram_din_i,
      output if_done_o, if_inst_o, ls_done_o, ls_rdata_o, ram_addr_o,
             ram_we_o, ram_dout_o
   );

   modport master (
      output if_req_i, if_addr_i, ls_req_i, ls_we_i, ls_size_i, ls_addr_i,
             ls_wdata_i, ram_din_i,
      input  if_done_o, if_inst_o, ls_done_o, ls_rdata_o, ram_addr_o,
             ram_we_o, ram_dout_o
   );
endinterface

// File: rtl/mem_ctrl_ibuf.sv
// One-entry instruction buffer {valid, tag, word} with hit compare; only
// instantiated when MEM_CTRL_IBUF_EN is defined.
module mem_ctrl_ibuf #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fill,
   input  logic [ADDR_W-1:0] fill_tag,
   input  logic [31:0]       fill_word,
   input  logic              clr,
   input  logic [ADDR_W-1:0] addr,
   output logic              hit,
   output logic [31:0]       word
);
   logic              valid_q;
   logic [ADDR_W-1:0] tag_q;
   logic [31:0]       word_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
         word_q  <= '0;
      end else if (clr) begin
         valid_q <= 1'b0;
      end else if (fill) begin
         valid_q <= 1'b1;
         tag_q   <= fill_tag;
         word_q  <= fill_word;
      end
   end

   assign hit  = valid_q && (addr == tag_q);
   assign word = word_q;
endmodule

// File: rtl/mem_ctrl.sv
// Shares one byte-wide synchronous RAM port between IF and load/store, splitting
// accesses into little-endian byte cycles. MEM_CTRL_IBUF_EN adds a fetch buffer.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int RAM_ADDR_W = 17
) (
   input  logic      clk,
   input  logic      rst,
   mem_ctrl_if.slave bus
);
   logic [1:0]                      state_q;
   req_t                            req_q;
   logic [RAM_ADDR_W-1:0]           cur_addr_q;
   logic [NUM_LANES-1:0][VEC_W-1:0] wdata_q;
   logic [1:0]                      cnt_q;
   logic [1:0]                      lane_q;
   logic [STAGES:0]                 vld_pipe;
   logic [NUM_LANES-1:0][VEC_W-1:0] asm_q, asm_nxt;
   logic [31:0]                     if_inst_q, ls_rdata_q;
   logic                            ibuf_hit;
   logic [31:0]                     ibuf_word;

   // Read data returns one cycle after its address; the pipe tags that cycle.
   assign vld_pipe[0] = (state_q == ST_ISSUE) && !req_q.we;

   always_ff @(posedge clk) begin
      if (rst) vld_pipe[STAGES:1] <= '0;
      else     vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
   end

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      assign asm_nxt[g] = (vld_pipe[STAGES] && lane_q == 2'(g)) ? bus.ram_din_i : asm_q[g];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         req_q      <= '0;
         cur_addr_q <= '0;
         wdata_q    <= '0;
         cnt_q      <= '0;
         lane_q     <= '0;
         asm_q      <= '0;
         if_inst_q  <= '0;
         ls_rdata_q <= '0;
      end else begin
         lane_q <= cnt_q;
         asm_q  <= asm_nxt;
         case (state_q)
            ST_IDLE: begin
               if (bus.ls_req_i) begin
                  req_q      <= '{owner: OWN_LS, we: bus.ls_we_i, last: last_lane(bus.ls_size_i)};
                  cur_addr_q <= bus.ls_addr_i[RAM_ADDR_W-1:0];
                  wdata_q    <= bus.ls_wdata_i;
                  cnt_q      <= '0;
                  asm_q      <= '0;
                  state_q    <= ST_ISSUE;
               end else if (bus.if_req_i) begin
                  req_q <= '{owner: OWN_IF, we: 1'b0, last: 2'd3};
                  cnt_q <= '0;
                  asm_q <= '0;
                  if (ibuf_hit) begin
                     if_inst_q <= ibuf_word;
                     state_q   <= ST_DONE;
                  end else begin
                     cur_addr_q <= bus.if_addr_i[RAM_ADDR_W-1:0];
                     state_q    <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               if (cnt_q == req_q.last) begin
                  state_q <= req_q.we ? ST_DONE : ST_LAST_RD;
               end else begin
                  cnt_q      <= cnt_q + 2'd1;
                  cur_addr_q <= cur_addr_q + RAM_ADDR_W'(1);
               end
            end
            ST_LAST_RD: begin
               state_q <= ST_DONE;
               if (req_q.owner == OWN_LS) ls_rdata_q <= asm_nxt;
               else                       if_inst_q  <= asm_nxt;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

`ifdef MEM_CTRL_IBUF_EN
   logic [ADDR_W-1:0] base_q;

   // Full fetch address kept for the tag; cur_addr_q only holds RAM bits.
   always_ff @(posedge clk) begin
      if (rst)
         base_q <= '0;
      else if (state_q == ST_IDLE && !bus.ls_req_i && bus.if_req_i)
         base_q <= bus.if_addr_i;
   end

   mem_ctrl_ibuf #(.ADDR_W(ADDR_W)) u_ibuf (
      .clk       (clk),
      .rst       (rst),
      .fill      (state_q == ST_LAST_RD && req_q.owner == OWN_IF),
      .fill_tag  (base_q),
      .fill_word (asm_nxt),
      .clr       (state_q == ST_IDLE && bus.ls_req_i && bus.ls_we_i),
      .addr      (bus.if_addr_i),
      .hit       (ibuf_hit),
      .word      (ibuf_word)
   );
`else
   assign ibuf_hit  = 1'b0;
   assign ibuf_word = '0;
`endif

   assign bus.if_done_o  = !rst && state_q == ST_DONE && req_q.owner == OWN_IF;
   assign bus.ls_done_o  = !rst && state_q == ST_DONE && req_q.owner == OWN_LS;
   assign bus.if_inst_o  = if_inst_q;
   assign bus.ls_rdata_o = ls_rdata_q;
   assign bus.ram_we_o   = !rst && state_q == ST_ISSUE && req_q.we;
   assign bus.ram_addr_o = cur_addr_q;
   assign bus.ram_dout_o = wdata_q[cnt_q];

endmodule
